uart_reg_bridge: RTL
====================

Name: uart_reg_bridge

Overview:
- Command responder for the byte side of simpleUART. Consumes received bytes through the r_valid/r_data/r_ready interface, decodes 'W'/'R' register commands, drives a simple 8-bit register bus, and returns response bytes through w_data/w_valid/w_ready.
- Lets a host PC peek and poke on-chip registers over the existing UART.

Parameters:
- CLK_FREQ, 27_000_000: clock frequency in Hz. Documentation only; not used in any arithmetic.
- BYTE_TIMEOUT, 2_700_000: idle cycles allowed between bytes of one command before the frame is abandoned.
- RD_TIMEOUT, 16: cycles allowed from reg_re to reg_rvalid.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- r_data  in  8  received byte (first-word-fall-through: valid whenever r_ready=1)
- r_ready  in  1  received byte available
- r_valid  out  1  pop request; the byte is consumed in the cycle where r_valid & r_ready = 1
- w_data  out  8  response byte
- w_valid  out  1  response byte request
- w_ready  in  1  UART TX FIFO can accept
- reg_addr  out  8  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, sampled when reg_rvalid=1
- reg_rvalid  in  1  read data valid
- busy  out  1  state != IDLE
- err_cnt  out  8  saturating NAK counter

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State goes to IDLE.
  - r_valid=0, w_valid=0, w_data=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, busy=0, err_cnt=0.
  - All timers are cleared. Reset mid-frame discards the frame; no strobe or response is issued.
- Frame formats:
  - Write: 0x57 ('W'), ADDR, DATA. Response: 0x06 (ACK).
  - Read: 0x52 ('R'), ADDR. Response: the read data byte.
  - Any other first byte: response 0x15 (NAK).
- Receive rule:
  - r_valid = r_ready & (state in {IDLE, GET_ADDR, GET_DATA, GET_CSUM}).
  - r_valid is the only combinational output.
  - r_data is captured in the same cycle, so exactly one byte is popped per accepted cycle.
- Transmit rule:
  - w_data and w_valid are registered.
  - w_valid is held with w_data stable until the cycle where w_valid & w_ready = 1, then drops to 0 in the next cycle.
  - Only one response byte per frame.
- States:
  - IDLE: on a byte, 'W' or 'R' -> GET_ADDR (opcode latched); other -> SEND with NAK.
  - GET_ADDR: byte -> reg_addr. For 'W' -> GET_DATA; for 'R' -> RD_REQ.
  - GET_DATA: byte -> reg_wdata -> WR.
  - WR: reg_we=1 for exactly one cycle -> SEND with ACK.
  - RD_REQ: reg_re=1 for exactly one cycle -> RD_WAIT.
  - RD_WAIT:
    - reg_rvalid=1 -> SEND with w_data=reg_rdata. reg_rvalid arriving in the same cycle as reg_re is ignored; sampling starts the cycle after.
    - Timeout: after RD_TIMEOUT cycles without reg_rvalid -> SEND with NAK.
  - SEND: on handshake -> IDLE.
- Byte timeout:
  - Counter runs in GET_ADDR, GET_DATA and GET_CSUM; it clears on each accepted byte.
  - On reaching BYTE_TIMEOUT, go to IDLE silently. No response; err_cnt is incremented.
- err_cnt: +1 on every NAK and every byte timeout; saturates at 0xFF, no wrap.
- Backpressure: while in SEND with w_ready=0, no RX bytes are consumed (r_valid=0). Received bytes remain queued in the UART FIFO.
- Read latency: from the reg_rvalid cycle to w_valid=1 is 1 cycle.
- Write latency: from the accept of the DATA byte to reg_we is 1 cycle; ACK w_valid follows 1 cycle later.

Optional Feature:
- Macro: UART_REG_BRIDGE_CSUM_EN.
- Defined:
  - Every frame carries a trailing CSUM byte = 8-bit sum (mod 256) of all preceding frame bytes, including the opcode.
  - GET_DATA (for 'W') or GET_ADDR (for 'R') goes to GET_CSUM instead of WR/RD_REQ.
  - Mismatch -> SEND with NAK. reg_we and reg_re are never asserted for a bad frame.
- Undefined: GET_CSUM state and sum logic are absent; frames are exactly as listed above.

Test Plan:
- Reset then idle: no bytes -> w_valid=0, reg_we=0, reg_re=0, busy=0, err_cnt=0 for 100 cycles. Assert RST_N=0 mid 'W' frame -> no reg_we and no ACK after release.
- Write: bytes 0x57,0x12,0xA5 -> one reg_we pulse with reg_addr=0x12, reg_wdata=0xA5, then w_data=0x06 handshake, then busy=0.
- Read: bytes 0x52,0x34; reg_rvalid=1 with reg_rdata=0x5C three cycles after reg_re -> w_data=0x5C. With reg_rvalid held 0 -> w_data=0x15 after 16 cycles, err_cnt=1.
- Unknown and timeout: byte 0x41 -> NAK, err_cnt +1. Bytes 0x57,0x12 then silence with BYTE_TIMEOUT=100 -> no response, err_cnt +1, back to IDLE. 300 errors -> err_cnt=0xFF.
- Backpressure: w_ready=0 for 50 cycles during ACK -> w_valid held, w_data stable, r_valid=0 despite r_ready=1. Next frame is processed correctly after release.
- CSUM_EN: 0x57,0x12,0xA5,0x0E -> write + ACK. Same frame with CSUM 0x0F -> NAK, no reg_we.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART byte-stream command responder driving an 8-bit register bus.
// Define UART_REG_BRIDGE_CSUM_EN to require a trailing mod-256 checksum byte per frame.
module uart_reg_bridge #(
    parameter int CLK_FREQ     = 27_000_000,
    parameter int BYTE_TIMEOUT = 2_700_000,
    parameter int RD_TIMEOUT   = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] r_data,
    input  logic       r_ready,
    output logic       r_valid,
    output logic [7:0] w_data,
    output logic       w_valid,
    input  logic       w_ready,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rvalid,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam int RW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
`ifdef UART_REG_BRIDGE_CSUM_EN
        S_GET_CSUM = 3'd3,
`endif
        S_WR       = 3'd4,
        S_RD_REQ   = 3'd5,
        S_RD_WAIT  = 3'd6,
        S_SEND     = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic            op_wr_q, op_wr_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      w_data_q, w_data_d;
    logic            w_valid_q, w_valid_d;
    logic            reg_we_q, reg_we_d;
    logic            reg_re_q, reg_re_d;
    logic            busy_q, busy_d;
    logic [7:0]      err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [RW-1:0]   rdc_q, rdc_d;
`ifdef UART_REG_BRIDGE_CSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    logic            in_get;
    logic            pop;
    logic            tmo_hit;
    logic            nak_ev;
    logic            resp_ev;
    logic [7:0]      resp_byte;

    // States that are waiting for an incoming frame byte
    always_comb begin
        in_get = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
`ifdef UART_REG_BRIDGE_CSUM_EN
        in_get = in_get || (state_q == S_GET_CSUM);
`endif
    end

    assign pop     = r_ready & ((state_q == S_IDLE) | in_get);
    assign r_valid = pop;
    assign tmo_hit = in_get & ~pop & (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; also selects the response byte on entry to SEND
    always_comb begin
        state_d   = state_q;
        nak_ev    = 1'b0;
        resp_ev   = 1'b0;
        resp_byte = NAK;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if ((r_data == OP_WR) || (r_data == OP_RD)) begin
                        state_d = S_GET_ADDR;
                    end else begin
                        state_d = S_SEND;
                        nak_ev  = 1'b1;
                        resp_ev = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (pop) begin
`ifdef UART_REG_BRIDGE_CSUM_EN
                    state_d = op_wr_q ? S_GET_DATA : S_GET_CSUM;
`else
                    state_d = op_wr_q ? S_GET_DATA : S_RD_REQ;
`endif
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (pop) begin
`ifdef UART_REG_BRIDGE_CSUM_EN
                    state_d = S_GET_CSUM;
`else
                    state_d = S_WR;
`endif
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
`ifdef UART_REG_BRIDGE_CSUM_EN
            S_GET_CSUM: begin
                if (pop) begin
                    if (r_data == sum_q) begin
                        state_d = op_wr_q ? S_WR : S_RD_REQ;
                    end else begin
                        state_d = S_SEND;
                        nak_ev  = 1'b1;
                        resp_ev = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
`endif
            S_WR: begin
                state_d   = S_SEND;
                resp_ev   = 1'b1;
                resp_byte = ACK;
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (reg_rvalid) begin
                    state_d   = S_SEND;
                    resp_ev   = 1'b1;
                    resp_byte = reg_rdata;
                end else if (rdc_q == RD_LAST) begin
                    state_d = S_SEND;
                    nak_ev  = 1'b1;
                    resp_ev = 1'b1;
                end
            end
            S_SEND: begin
                if (w_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of registered outputs, captured fields and timers
    always_comb begin
        w_valid_d = (state_d == S_SEND);
        w_data_d  = resp_ev ? resp_byte : w_data_q;
        reg_we_d  = (state_d == S_WR);
        reg_re_d  = (state_d == S_RD_REQ);
        busy_d    = (state_d != S_IDLE);
        err_d     = err_q;
        if ((nak_ev || tmo_hit) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        op_wr_d = op_wr_q;
        if (pop && (state_q == S_IDLE)) begin
            op_wr_d = (r_data == OP_WR);
        end
        addr_d = addr_q;
        if (pop && (state_q == S_GET_ADDR)) begin
            addr_d = r_data;
        end
        wdata_d = wdata_q;
        if (pop && (state_q == S_GET_DATA)) begin
            wdata_d = r_data;
        end
        tmo_d = (in_get && !pop && !tmo_hit) ? tmo_q + 1'b1 : '0;
        rdc_d = (state_q == S_RD_WAIT) ? rdc_q + 1'b1 : '0;
`ifdef UART_REG_BRIDGE_CSUM_EN
        sum_d = sum_q;
        if (pop && (state_q == S_IDLE)) begin
            sum_d = r_data;
        end else if (pop && ((state_q == S_GET_ADDR) || (state_q == S_GET_DATA))) begin
            sum_d = sum_q + r_data;
        end
`endif
    end

    // Output, datapath and timer registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            w_data_q  <= '0;
            w_valid_q <= 1'b0;
            reg_we_q  <= 1'b0;
            reg_re_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= '0;
            tmo_q     <= '0;
            rdc_q     <= '0;
`ifdef UART_REG_BRIDGE_CSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
            reg_we_q  <= reg_we_d;
            reg_re_q  <= reg_re_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            rdc_q     <= rdc_d;
`ifdef UART_REG_BRIDGE_CSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign w_data    = w_data_q;
    assign w_valid   = w_valid_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;
    assign err_cnt   = err_q;

endmodule
